mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arb_timer.sv | 25 ++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default sizing for the memory port arbiter
package mem_arb_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int STARVE_MAX_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} arbState_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts memory wait cycles of the granted transaction
//   clock/reset_n : clock, async active-low reset
//   clear         : restart count (grant)
//   enable        : count this cycle (busy, memory not ready)
//   expired       : count has reached TIMEOUT
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] waitCnt;
  assign expired = waitCnt == W'(TIMEOUT);
  // holds at TIMEOUT so the count never wraps while the abort is taken
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) waitCnt <= '0;
    else if (clear) waitCnt <= '0;
    else if (enable && !expired) waitCnt <= waitCnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
//   if_*   : fetch requester (read only), if_valid pulses on completion
//   dm_*   : data requester (load/store), dm_valid pulses on completion
//   mem_*  : shared memory port; mem_err pulses on a timeout abort
//   stall_f/stall_m : combinational stalls while a request is outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_err,
  output logic            stall_f,
  output logic            stall_m
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arbState_t state;
  logic [SW-1:0] starveCnt;
  logic ifReqEff, dmReqEff, grantData, grantFetch, busy, expired, done, abort;
  // a requester whose valid is high this cycle is still holding its old request
  assign ifReqEff = if_req && !if_valid;
  assign dmReqEff = dm_req && !dm_valid;
  assign grantData = state == IDLE && dmReqEff && !(ifReqEff && starveCnt == SW'(STARVE_MAX));
  assign grantFetch = state == IDLE && ifReqEff && !grantData;
  assign busy = state != IDLE;
  assign done = busy && mem_ready;
  assign abort = busy && !mem_ready && expired;
  assign mem_req = busy;
  assign stall_f = if_req && !if_valid;
  assign stall_m = dm_req && !dm_valid;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (grantData || grantFetch),
    .enable (busy && !mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      starveCnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      dm_rdata <= '0;
      dm_valid <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      mem_err <= 1'b0;
      if (grantData) begin
        state <= DATA;
        mem_addr <= dm_addr;
        mem_we <= dm_we;
        mem_wdata <= dm_wdata;
        starveCnt <= (if_req && starveCnt != SW'(STARVE_MAX)) ? starveCnt + 1'b1 : starveCnt;
      end else if (grantFetch) begin
        state <= FETCH;
        mem_addr <= if_addr;
        mem_we <= 1'b0;
        mem_wdata <= '0;
        starveCnt <= '0;
      end else if (done || abort) begin
        state <= IDLE;
        mem_err <= abort;
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          dm_valid <= 1'b1;
          if (!mem_we) dm_rdata <= done ? mem_rdata : '0;
        end
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle corner sequences
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  logic ifReq, dmReq, dmWe, memReady;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_valid, dm_valid, mem_req, mem_we, mem_err, stall_f, stall_m;
  int nCmp = 0;
  int nBad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_req   (ifReq),
    .if_addr  (ifAddr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dmReq),
    .dm_we    (dmWe),
    .dm_addr  (dmAddr),
    .dm_wdata (dmWdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(memRdata),
    .mem_ready(memReady),
    .mem_err  (mem_err),
    .stall_f  (stall_f),
    .stall_m  (stall_m)
  );

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic [31:0] mr; logic rdy;
    logic eReq; logic eWe; logic [31:0] eAddr; logic [31:0] eWd; logic eIfV; logic [31:0] eIfR;
    logic eDmV; logic [31:0] eDmR; logic eErr; logic eStF; logic eStM;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr, input logic rdy,
    input logic eReq, input logic eWe, input logic [31:0] eAddr, input logic [31:0] eWd,
    input logic eIfV, input logic [31:0] eIfR, input logic eDmV, input logic [31:0] eDmR,
    input logic eErr, input logic eStF, input logic eStM);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr; v.rdy = rdy;
    v.eReq = eReq; v.eWe = eWe; v.eAddr = eAddr; v.eWd = eWd; v.eIfV = eIfV; v.eIfR = eIfR;
    v.eDmV = eDmV; v.eDmR = eDmR; v.eErr = eErr; v.eStF = eStF; v.eStM = eStM;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
                     input logic rdy);
    ifReq = ir; ifAddr = ia; dmReq = dr; dmWe = dw; dmAddr = da; dmWdata = dd;
    memRdata = mr; memReady = rdy;
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    // single fetch, held request ignored during if_valid, then data-first arbitration
    vecs[0] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
    vecs[1] = mk(1, 32'h100, 0, 0, 0, 0, 32'h00500093, 1,
                 1, 0, 32'h100, 0, 0, 32'h0, 0, 0, 0, 1, 0);
    vecs[2] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h100, 0, 1, 32'h00500093, 0, 0, 0, 0, 0);
    vecs[3] = mk(0, 32'h100, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h100, 0, 0, 32'h00500093, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 0,
                 0, 0, 32'h100, 0, 0, 32'h00500093, 0, 0, 0, 1, 1);
    vecs[5] = mk(1, 32'h104, 1, 1, 32'h2004, 32'h12345678, 32'hCAFEF00D, 1,
                 1, 1, 32'h2000, 32'hDEADBEEF, 0, 32'h00500093, 0, 0, 0, 1, 1);
    vecs[6] = mk(1, 32'h104, 1, 1, 32'h2004, 32'h12345678, 0, 0,
                 0, 1, 32'h2000, 32'hDEADBEEF, 0, 32'h00500093, 1, 0, 0, 1, 0);
    vecs[7] = mk(1, 32'h104, 0, 0, 0, 0, 32'h11111111, 1,
                 1, 0, 32'h104, 0, 0, 32'h00500093, 0, 0, 0, 1, 0);
    vecs[8] = mk(1, 32'h104, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h104, 0, 1, 32'h11111111, 0, 0, 0, 0, 0);
    vecs[9] = mk(0, 32'h104, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h104, 0, 0, 32'h11111111, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_valids_err", {if_valid, dm_valid, mem_err, mem_we}, 0);
    adv();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drv(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].mr, vecs[i].rdy);
      @(negedge clock);
      chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].eReq);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].eWe);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].eAddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].eWd);
      chk($sformatf("v%0d_if_valid", i), if_valid, vecs[i].eIfV);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].eIfR);
      chk($sformatf("v%0d_dm_valid", i), dm_valid, vecs[i].eDmV);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].eDmR);
      chk($sformatf("v%0d_mem_err", i), mem_err, vecs[i].eErr);
      chk($sformatf("v%0d_stall_f", i), stall_f, vecs[i].eStF);
      chk($sformatf("v%0d_stall_m", i), stall_m, vecs[i].eStM);
      adv();
    end

    // starvation: fetch withdraws only in each dm_valid cycle so four data grants
    // accumulate with fetch pending; the next contested grant must go to fetch
    for (int t = 0; t < 4; t++) begin
      a = 32'h4000 + 32'(4 * t);
      drv(1, 32'h300, 1, 0, a, 0, 0, 0);
      @(negedge clock); chk($sformatf("starve_idle%0d", t), mem_req, 0); adv();
      drv(1, 32'h300, 1, 0, a, 0, 32'hA5A50000 + 32'(t), 1);
      @(negedge clock); chk($sformatf("starve_dgrant%0d", t), mem_addr, a); adv();
      drv(0, 32'h300, 1, 0, a, 0, 0, 0);
      @(negedge clock);
      chk($sformatf("starve_dvalid%0d", t), dm_valid, 1);
      chk($sformatf("starve_drdata%0d", t), dm_rdata, 32'hA5A50000 + 32'(t));
      adv();
    end
    drv(1, 32'h300, 1, 0, 32'h4010, 0, 0, 0);
    @(negedge clock); adv();
    drv(1, 32'h300, 1, 0, 32'h4010, 0, 32'h0BADF00D, 1);
    @(negedge clock);
    chk("starve_fgrant_addr", mem_addr, 32'h300);
    chk("starve_fgrant_we", mem_we, 0);
    adv();
    drv(1, 32'h300, 1, 0, 32'h4010, 0, 0, 0);
    @(negedge clock);
    chk("starve_if_valid", if_valid, 1);
    chk("starve_if_rdata", if_rdata, 32'h0BADF00D);
    adv();
    drv(0, 32'h300, 1, 0, 32'h4010, 0, 32'hA5A50004, 1);
    @(negedge clock); chk("starve_after_fetch_addr", mem_addr, 32'h4010); adv();
    drv(0, 32'h300, 1, 0, 32'h4010, 0, 0, 0);
    @(negedge clock); chk("starve_after_fetch_dvalid", dm_valid, 1); adv();
    drv(1, 32'h308, 1, 0, 32'h4014, 0, 0, 0);
    @(negedge clock); adv();
    drv(1, 32'h308, 1, 0, 32'h4014, 0, 32'hA5A50005, 1);
    @(negedge clock); chk("starve_cleared_dgrant", mem_addr, 32'h4014); adv();
    drv(1, 32'h308, 0, 0, 32'h4014, 0, 0, 0);
    @(negedge clock); chk("starve_cleared_dvalid", dm_valid, 1); adv();
    drv(1, 32'h308, 0, 0, 0, 0, 32'h00000013, 1);
    @(negedge clock); chk("starve_last_fetch_addr", mem_addr, 32'h308); adv();
    drv(1, 32'h308, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("starve_last_if_valid", if_valid, 1); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); adv();

    // timeout: load never acknowledged, abort lands TIMEOUT+2 cycles after request
    drv(0, 0, 1, 0, 32'h5000, 0, 32'hFFFFFFFF, 0);
    @(negedge clock); chk("to_c0_stall_m", stall_m, 1); adv();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk($sformatf("to_wait%0d", k), {29'b0, mem_req, mem_err, dm_valid}, 32'b100);
      adv();
    end
    @(negedge clock);
    chk("to_mem_err", mem_err, 1);
    chk("to_dm_valid", dm_valid, 1);
    chk("to_dm_rdata", dm_rdata, 0);
    chk("to_idle", mem_req, 0);
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("to_err_pulse", mem_err, 0); adv();

    // ready arriving on the last allowed wait cycle completes normally
    drv(0, 0, 1, 0, 32'h6000, 0, 0, 0);
    @(negedge clock); adv();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      chk($sformatf("lim_wait%0d", k), {30'b0, mem_err, dm_valid}, 0);
      adv();
    end
    drv(0, 0, 1, 0, 32'h6000, 0, 32'h77778888, 1);
    @(negedge clock); chk("lim_busy", mem_req, 1); adv();
    drv(0, 0, 1, 0, 32'h6000, 0, 0, 0);
    @(negedge clock);
    chk("lim_dm_valid", dm_valid, 1);
    chk("lim_mem_err", mem_err, 0);
    chk("lim_dm_rdata", dm_rdata, 32'h77778888);
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); adv();

    // reset in the middle of a data wait abandons it silently
    drv(0, 0, 1, 0, 32'h7000, 0, 0, 0);
    @(negedge clock); adv();
    @(negedge clock); chk("mrst_busy", mem_req, 1); adv();
    reset_n = 1'b0;
    #1;
    chk("mrst_mem_req_async", mem_req, 0);
    chk("mrst_if_rdata", if_rdata, 0);
    chk("mrst_dm_rdata", dm_rdata, 0);
    @(negedge clock); adv();
    drv(1, 32'h400, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mrst_no_valid_err", {29'b0, dm_valid, mem_err, mem_req}, 0);
    adv();
    drv(1, 32'h400, 0, 0, 0, 0, 32'h00000099, 1);
    @(negedge clock);
    chk("mrst_fetch_req", mem_req, 1);
    chk("mrst_fetch_addr", mem_addr, 32'h400);
    adv();
    drv(1, 32'h400, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("mrst_if_valid", if_valid, 1);
    chk("mrst_if_rdata2", if_rdata, 32'h99);
    chk("mrst_no_dm_valid", dm_valid, 0);
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
